// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX-stage operand forwarding plus load-use / multiply hazard control
// for the 5-stage pipeline. Sits beside the ID/EX register.
// Optional statistics counters are built when FWD_HAZARD_STATS_EN is defined.
module fwd_hazard_ctrl #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int MUL_LAT = 3
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic [NUM_SRC*REG_AW-1:0]   i_id_src,
    input  logic [NUM_SRC-1:0]          i_id_src_used,
    input  logic [NUM_SRC*REG_AW-1:0]   i_ex_src,
    input  logic [NUM_SRC*DATA_W-1:0]   i_ex_rf_data,
    input  logic                        i_ex_valid,
    input  logic [REG_AW-1:0]           i_ex_dst,
    input  logic                        i_ex_wen,
    input  logic                        i_ex_is_load,
    input  logic                        i_ex_is_mul,
    input  logic [REG_AW-1:0]           i_mem_dst,
    input  logic                        i_mem_wen,
    input  logic                        i_mem_is_load,
    input  logic [DATA_W-1:0]           i_mem_result,
    input  logic [REG_AW-1:0]           i_wb_dst,
    input  logic                        i_wb_wen,
    input  logic [DATA_W-1:0]           i_wb_data,
    input  logic                        i_pipe_flush,
    output logic [NUM_SRC*DATA_W-1:0]   o_fwd_data,
    output logic [NUM_SRC*2-1:0]        o_fwd_sel,
    output logic                        o_stall_if,
    output logic                        o_stall_id,
    output logic                        o_stall_ex,
    output logic                        o_bubble_ex,
    output logic                        o_mul_busy
`ifdef FWD_HAZARD_STATS_EN
    ,
    output logic [31:0]                 o_stat_fwd_mem,
    output logic [31:0]                 o_stat_fwd_wb,
    output logic [31:0]                 o_stat_loaduse,
    output logic [31:0]                 o_stat_mulstall
`endif
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL_BUSY = 2'd1,
        S_MUL_DONE = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(MUL_LAT + 1);
    // Busy phase lasts MUL_LAT-1 cycles; the done cycle supplies the last EX cycle.
    localparam logic [CNT_W-1:0] CNT_LOAD  = (MUL_LAT > 1) ? CNT_W'(MUL_LAT - 2) : '0;
    localparam bit               MUL_MULTI = (MUL_LAT > 1);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;

    logic [NUM_SRC-1:0] w_hit_mem;
    logic [NUM_SRC-1:0] w_hit_wb;
    logic [NUM_SRC-1:0] w_lu_hit;
    logic               w_busy;
    logic               w_kill;
    logic               w_lu;

    // Per-source forwarding muxes and load-use address compares.
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        logic [REG_AW-1:0] w_addr;
        logic [REG_AW-1:0] w_id_addr;

        assign w_addr    = i_ex_src[g*REG_AW +: REG_AW];
        assign w_id_addr = i_id_src[g*REG_AW +: REG_AW];

        // A load in MEM is never a forwarding source: its data is not ready yet.
        assign w_hit_mem[g] = i_mem_wen & ~i_mem_is_load & (i_mem_dst != '0) & (i_mem_dst == w_addr);
        assign w_hit_wb[g]  = i_wb_wen & (i_wb_dst != '0) & (i_wb_dst == w_addr);
        assign w_lu_hit[g]  = i_id_src_used[g] & (w_id_addr == i_ex_dst);

        // Operand select with MEM > WB > regfile priority.
        always_comb begin
            o_fwd_sel[g*2 +: 2]           = SEL_RF;
            o_fwd_data[g*DATA_W +: DATA_W] = i_ex_rf_data[g*DATA_W +: DATA_W];
            if (w_hit_mem[g]) begin
                o_fwd_sel[g*2 +: 2]           = SEL_MEM;
                o_fwd_data[g*DATA_W +: DATA_W] = i_mem_result;
            end else if (w_hit_wb[g]) begin
                o_fwd_sel[g*2 +: 2]           = SEL_WB;
                o_fwd_data[g*DATA_W +: DATA_W] = i_wb_data;
            end
        end
    end

    // Stall/bubble decode: busy stall from state, load-use from EX/ID compare; reset and flush mask all.
    always_comb begin
        w_kill      = i_reset | i_pipe_flush;
        w_busy      = (r_state == S_MUL_BUSY);
        // A combined load+mul is treated as a multiply, so it never raises load-use.
        w_lu        = ~w_busy & i_ex_valid & i_ex_wen & i_ex_is_load & ~i_ex_is_mul &
                      (i_ex_dst != '0) & (|w_lu_hit);
        o_stall_ex  = w_busy & ~w_kill;
        o_bubble_ex = w_lu & ~w_kill;
        o_stall_if  = o_stall_ex | o_bubble_ex;
        o_stall_id  = o_stall_ex | o_bubble_ex;
        o_mul_busy  = w_busy;
    end

    // Multiply stall FSM with latency counter; flush and reset abort to IDLE.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_pipe_flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (MUL_MULTI && i_ex_valid && i_ex_is_mul) begin
                        r_state <= S_MUL_BUSY;
                        r_cnt   <= CNT_LOAD;
                    end
                end
                S_MUL_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= S_MUL_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                // The multiply leaves EX this cycle; ex_is_mul still shows it, so no restart here.
                S_MUL_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] r_stat_fwd_mem;
    logic [31:0] r_stat_fwd_wb;
    logic [31:0] r_stat_loaduse;
    logic [31:0] r_stat_mulstall;

    // Saturating event counters for performance analysis.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stat_fwd_mem  <= '0;
            r_stat_fwd_wb   <= '0;
            r_stat_loaduse  <= '0;
            r_stat_mulstall <= '0;
        end else begin
            if (i_ex_valid && (|w_hit_mem) && (r_stat_fwd_mem != '1))
                r_stat_fwd_mem <= r_stat_fwd_mem + 32'd1;
            if (i_ex_valid && (|(w_hit_wb & ~w_hit_mem)) && (r_stat_fwd_wb != '1))
                r_stat_fwd_wb <= r_stat_fwd_wb + 32'd1;
            if (o_bubble_ex && (r_stat_loaduse != '1))
                r_stat_loaduse <= r_stat_loaduse + 32'd1;
            if (w_busy && (r_stat_mulstall != '1))
                r_stat_mulstall <= r_stat_mulstall + 32'd1;
        end
    end

    assign o_stat_fwd_mem  = r_stat_fwd_mem;
    assign o_stat_fwd_wb   = r_stat_fwd_wb;
    assign o_stat_loaduse  = r_stat_loaduse;
    assign o_stat_mulstall = r_stat_mulstall;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural model (remaining-stall-cycles view of the multiply).
module tb_fwd_hazard_ctrl;
    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int NUM_SRC = 2;
    localparam int MUL_LAT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      reset;
    logic [NUM_SRC*REG_AW-1:0] id_src, ex_src;
    logic [NUM_SRC-1:0]        id_src_used;
    logic [NUM_SRC*DATA_W-1:0] ex_rf_data, fwd_data;
    logic                      ex_valid, ex_wen, ex_is_load, ex_is_mul;
    logic [REG_AW-1:0]         ex_dst, mem_dst, wb_dst;
    logic                      mem_wen, mem_is_load, wb_wen, pipe_flush;
    logic [DATA_W-1:0]         mem_result, wb_data;
    logic [NUM_SRC*2-1:0]      fwd_sel;
    logic                      stall_if, stall_id, stall_ex, bubble_ex, mul_busy;
`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] stat_fwd_mem, stat_fwd_wb, stat_loaduse, stat_mulstall;
    int unsigned m_fwd_mem, m_fwd_wb, m_loaduse, m_mulstall;
`endif

    int checks = 0;
    int errors = 0;
    // Reference model of the multiply stall: cycles of stall still owed, plus the one free cycle after.
    int m_busy_left = 0;
    bit m_done = 1'b0;

    fwd_hazard_ctrl #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .MUL_LAT(MUL_LAT)) dut (
        .i_clk(clk), .i_reset(reset), .i_id_src(id_src), .i_id_src_used(id_src_used),
        .i_ex_src(ex_src), .i_ex_rf_data(ex_rf_data), .i_ex_valid(ex_valid), .i_ex_dst(ex_dst),
        .i_ex_wen(ex_wen), .i_ex_is_load(ex_is_load), .i_ex_is_mul(ex_is_mul),
        .i_mem_dst(mem_dst), .i_mem_wen(mem_wen), .i_mem_is_load(mem_is_load),
        .i_mem_result(mem_result), .i_wb_dst(wb_dst), .i_wb_wen(wb_wen), .i_wb_data(wb_data),
        .i_pipe_flush(pipe_flush), .o_fwd_data(fwd_data), .o_fwd_sel(fwd_sel),
        .o_stall_if(stall_if), .o_stall_id(stall_id), .o_stall_ex(stall_ex),
        .o_bubble_ex(bubble_ex), .o_mul_busy(mul_busy)
`ifdef FWD_HAZARD_STATS_EN
        , .o_stat_fwd_mem(stat_fwd_mem), .o_stat_fwd_wb(stat_fwd_wb),
        .o_stat_loaduse(stat_loaduse), .o_stat_mulstall(stat_mulstall)
`endif
    );

    // Source i's expected select: MEM (non-load, nonzero) beats WB (nonzero) beats regfile.
    function automatic logic [1:0] exp_sel(int i);
        logic [REG_AW-1:0] a;
        a = ex_src[i*REG_AW +: REG_AW];
        if (a != 0 && mem_wen && !mem_is_load && mem_dst == a) return 2'b10;
        if (a != 0 && wb_wen && wb_dst == a) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [DATA_W-1:0] exp_data(int i);
        case (exp_sel(i))
            2'b10:   return mem_result;
            2'b01:   return wb_data;
            default: return ex_rf_data[i*DATA_W +: DATA_W];
        endcase
    endfunction

    function automatic bit exp_lu();
        bit dep = 1'b0;
        for (int i = 0; i < NUM_SRC; i++)
            if (id_src_used[i] && id_src[i*REG_AW +: REG_AW] == ex_dst) dep = 1'b1;
        return dep && m_busy_left == 0 && ex_valid && ex_wen && ex_is_load && !ex_is_mul &&
               ex_dst != 0 && !reset && !pipe_flush;
    endfunction

    // {stall_if, stall_id, stall_ex, bubble_ex, mul_busy}
    function automatic logic [4:0] exp_ctl();
        bit st, lu;
        st = (m_busy_left > 0) && !reset && !pipe_flush;
        lu = exp_lu();
        return {st | lu, st | lu, st, lu, m_busy_left > 0};
    endfunction

    task automatic clear_inputs();
        reset = 0; id_src = '0; id_src_used = '0; ex_src = '0; ex_rf_data = '0;
        ex_valid = 0; ex_dst = '0; ex_wen = 0; ex_is_load = 0; ex_is_mul = 0;
        mem_dst = '0; mem_wen = 0; mem_is_load = 0; mem_result = '0;
        wb_dst = '0; wb_wen = 0; wb_data = '0; pipe_flush = 0;
    endtask

    // Advance one clock: update the model from the inputs seen at the edge, then release for new drive.
    task automatic step();
        bit any_mem, any_wb;
        @(posedge clk);
`ifdef FWD_HAZARD_STATS_EN
        any_mem = 0; any_wb = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (exp_sel(i) == 2'b10) any_mem = 1;
            if (exp_sel(i) == 2'b01) any_wb = 1;
        end
        if (reset) begin
            m_fwd_mem = 0; m_fwd_wb = 0; m_loaduse = 0; m_mulstall = 0;
        end else begin
            if (ex_valid && any_mem && m_fwd_mem != 32'hFFFF_FFFF) m_fwd_mem++;
            if (ex_valid && any_wb && m_fwd_wb != 32'hFFFF_FFFF) m_fwd_wb++;
            if (exp_lu() && m_loaduse != 32'hFFFF_FFFF) m_loaduse++;
            if (m_busy_left > 0 && m_mulstall != 32'hFFFF_FFFF) m_mulstall++;
        end
`else
        any_mem = 0; any_wb = 0;
`endif
        if (reset || pipe_flush) begin
            m_busy_left = 0; m_done = 0;
        end else if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) m_done = 1;
        end else if (m_done) begin
            m_done = 0;
        end else if (ex_valid && ex_is_mul && MUL_LAT > 1) begin
            m_busy_left = MUL_LAT - 1;
        end
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        step(); step();
        reset = 0;
        @(negedge clk);
        checks++;
        if ({stall_if, stall_id, stall_ex, bubble_ex, mul_busy} !== 5'b0) begin
            errors++; $display("FAIL reset_ctl got %b exp 00000", {stall_if, stall_id, stall_ex, bubble_ex, mul_busy});
        end
        checks++;
        if (fwd_sel !== '0) begin errors++; $display("FAIL reset_sel got %h exp 0", fwd_sel); end
`ifdef FWD_HAZARD_STATS_EN
        checks++;
        if ({stat_fwd_mem, stat_fwd_wb, stat_loaduse, stat_mulstall} !== '0) begin
            errors++; $display("FAIL reset_stats got %h %h %h %h exp 0", stat_fwd_mem, stat_fwd_wb, stat_loaduse, stat_mulstall);
        end
`endif
        step();
    endtask

    task automatic test_fwd_priority();
        clear_inputs();
        ex_valid = 1;
        mem_dst = 3; mem_wen = 1; mem_result = 32'h11;
        wb_dst = 3; wb_wen = 1; wb_data = 32'h22;
        ex_src = {5'd0, 5'd3};
        ex_rf_data = {32'h0, 32'hAAAA_0000};
        @(negedge clk);
        checks++;
        if (fwd_sel[1:0] !== 2'b10 || fwd_data[31:0] !== 32'h11) begin
            errors++; $display("FAIL fwd_mem_wins got %b/%h exp 10/00000011", fwd_sel[1:0], fwd_data[31:0]);
        end
        // Register 0 is never forwarded, even with WB writing r0.
        step();
        wb_dst = 0;
        @(negedge clk);
        checks++;
        if (fwd_sel[3:2] !== 2'b00 || fwd_data[63:32] !== 32'h0) begin
            errors++; $display("FAIL fwd_r0 got %b/%h exp 00/00000000", fwd_sel[3:2], fwd_data[63:32]);
        end
        // A load in MEM is skipped; WB supplies the value instead.
        step();
        wb_dst = 3; mem_is_load = 1;
        @(negedge clk);
        checks++;
        if (fwd_sel[1:0] !== 2'b01 || fwd_data[31:0] !== 32'h22) begin
            errors++; $display("FAIL fwd_mem_load_skip got %b/%h exp 01/00000022", fwd_sel[1:0], fwd_data[31:0]);
        end
        // No producer at all: regfile value passes through.
        step();
        wb_wen = 0;
        @(negedge clk);
        checks++;
        if (fwd_sel[1:0] !== 2'b00 || fwd_data[31:0] !== 32'hAAAA_0000) begin
            errors++; $display("FAIL fwd_regfile got %b/%h exp 00/aaaa0000", fwd_sel[1:0], fwd_data[31:0]);
        end
        step();
    endtask

    task automatic test_load_use();
        clear_inputs();
        ex_valid = 1; ex_wen = 1; ex_is_load = 1; ex_dst = 5;
        id_src = {5'd0, 5'd5}; id_src_used = 2'b00;
        @(negedge clk);
        checks++;
        if ({stall_if, stall_id, bubble_ex} !== 3'b000) begin
            errors++; $display("FAIL lu_unused got %b exp 000", {stall_if, stall_id, bubble_ex});
        end
        step();
        id_src_used = 2'b01;
        @(negedge clk);
        checks++;
        if ({stall_if, stall_id, stall_ex, bubble_ex} !== 4'b1101) begin
            errors++; $display("FAIL lu_bubble got %b exp 1101", {stall_if, stall_id, stall_ex, bubble_ex});
        end
        step();
        // Bubble now in EX, load in WB; dependent op sits in EX one cycle later.
        clear_inputs();
        ex_valid = 1; ex_src = {5'd0, 5'd5};
        wb_dst = 5; wb_wen = 1; wb_data = 32'hBEEF;
        @(negedge clk);
        checks++;
        if (fwd_sel[1:0] !== 2'b01 || fwd_data[31:0] !== 32'hBEEF || stall_if !== 1'b0) begin
            errors++; $display("FAIL lu_wb_fwd got %b/%h/%b exp 01/0000beef/0", fwd_sel[1:0], fwd_data[31:0], stall_if);
        end
        step();
    endtask

    task automatic test_mul();
        int busy_cycles = 0;
        int guard = 0;
        clear_inputs();
        // Load+mul with a dependent ID: multiply wins, no load-use bubble.
        ex_valid = 1; ex_wen = 1; ex_is_mul = 1; ex_is_load = 1; ex_dst = 5;
        id_src = {5'd0, 5'd5}; id_src_used = 2'b01;
        @(negedge clk);
        checks++;
        if ({bubble_ex, stall_ex} !== 2'b00) begin
            errors++; $display("FAIL mul_load_no_lu got %b exp 00", {bubble_ex, stall_ex});
        end
        step();
        while (mul_busy === 1'b1 && guard < 10) begin
            @(negedge clk);
            checks++;
            if ({stall_if, stall_id, stall_ex, bubble_ex} !== 4'b1110) begin
                errors++; $display("FAIL mul_busy_ctl got %b exp 1110", {stall_if, stall_id, stall_ex, bubble_ex});
            end
            busy_cycles++; guard++;
            step();
        end
        checks++;
        if (busy_cycles != MUL_LAT - 1) begin
            errors++; $display("FAIL mul_busy_len got %0d exp %0d", busy_cycles, MUL_LAT - 1);
        end
        // Done cycle: ex_is_mul still high, no stalls and no restart.
        @(negedge clk);
        checks++;
        if ({stall_if, stall_id, stall_ex, bubble_ex, mul_busy} !== 5'b0) begin
            errors++; $display("FAIL mul_done got %b exp 00000", {stall_if, stall_id, stall_ex, bubble_ex, mul_busy});
        end
        step();
        ex_valid = 0;
        @(negedge clk);
        checks++;
        if (mul_busy !== 1'b0) begin errors++; $display("FAIL mul_no_retrigger got %b exp 0", mul_busy); end
        step();
    endtask

    task automatic test_abort(input bit use_reset);
        clear_inputs();
        ex_valid = 1; ex_is_mul = 1;
        step();
        if (use_reset) reset = 1; else pipe_flush = 1;
        @(negedge clk);
        checks++;
        if ({stall_if, stall_id, stall_ex, bubble_ex, mul_busy} !== 5'b00001) begin
            errors++; $display("FAIL abort%0d_same_cycle got %b exp 00001", use_reset, {stall_if, stall_id, stall_ex, bubble_ex, mul_busy});
        end
        step();
        clear_inputs();
        @(negedge clk);
        checks++;
        if ({stall_ex, mul_busy} !== 2'b00) begin
            errors++; $display("FAIL abort%0d_idle got %b exp 00", use_reset, {stall_ex, mul_busy});
        end
        step();
    endtask

    task automatic test_random();
        logic [NUM_SRC*2-1:0]      e_sel;
        logic [NUM_SRC*DATA_W-1:0] e_data;
        for (int c = 0; c < 400; c++) begin
            reset       = ($urandom_range(0, 63) == 0);
            pipe_flush  = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < NUM_SRC; i++) begin
                id_src[i*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 3));
                ex_src[i*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 3));
                ex_rf_data[i*DATA_W +: DATA_W] = $urandom;
            end
            id_src_used = NUM_SRC'($urandom);
            ex_valid    = ($urandom_range(0, 3) != 0);
            ex_dst      = REG_AW'($urandom_range(0, 3));
            ex_wen      = $urandom_range(0, 1);
            ex_is_load  = ($urandom_range(0, 2) == 0);
            ex_is_mul   = ($urandom_range(0, 7) == 0);
            mem_dst     = REG_AW'($urandom_range(0, 3));
            mem_wen     = $urandom_range(0, 1);
            mem_is_load = ($urandom_range(0, 3) == 0);
            mem_result  = $urandom;
            wb_dst      = REG_AW'($urandom_range(0, 3));
            wb_wen      = $urandom_range(0, 1);
            wb_data     = $urandom;
            @(negedge clk);
            for (int i = 0; i < NUM_SRC; i++) begin
                e_sel[i*2 +: 2] = exp_sel(i);
                e_data[i*DATA_W +: DATA_W] = exp_data(i);
            end
            checks++;
            if (fwd_sel !== e_sel || fwd_data !== e_data) begin
                errors++; $display("FAIL rand_fwd cyc %0d got %h/%h exp %h/%h", c, fwd_sel, fwd_data, e_sel, e_data);
            end
            checks++;
            if ({stall_if, stall_id, stall_ex, bubble_ex, mul_busy} !== exp_ctl()) begin
                errors++; $display("FAIL rand_ctl cyc %0d got %b exp %b", c, {stall_if, stall_id, stall_ex, bubble_ex, mul_busy}, exp_ctl());
            end
`ifdef FWD_HAZARD_STATS_EN
            checks++;
            if (stat_fwd_mem !== m_fwd_mem || stat_fwd_wb !== m_fwd_wb ||
                stat_loaduse !== m_loaduse || stat_mulstall !== m_mulstall) begin
                errors++; $display("FAIL rand_stats cyc %0d got %0d %0d %0d %0d exp %0d %0d %0d %0d", c,
                    stat_fwd_mem, stat_fwd_wb, stat_loaduse, stat_mulstall, m_fwd_mem, m_fwd_wb, m_loaduse, m_mulstall);
            end
`endif
            step();
        end
        clear_inputs();
        step(); step();
    endtask

`ifdef FWD_HAZARD_STATS_EN
    task automatic test_stats();
        clear_inputs();
        reset = 1; step(); reset = 0;
        for (int k = 0; k < 2; k++) begin
            ex_valid = 1; ex_wen = 1; ex_is_load = 1; ex_dst = 5;
            id_src = {5'd0, 5'd5}; id_src_used = 2'b01;
            step();
            clear_inputs(); step();
        end
        ex_valid = 1; ex_is_mul = 1;
        for (int k = 0; k < MUL_LAT + 1; k++) step();
        clear_inputs(); step();
        @(negedge clk);
        checks++;
        if (stat_loaduse !== 32'd2 || stat_mulstall !== 32'd2) begin
            errors++; $display("FAIL stats_counts got %0d/%0d exp 2/2", stat_loaduse, stat_mulstall);
        end
        step();
    endtask
`endif

    initial begin
        clear_inputs();
        test_reset();
        test_fwd_priority();
        test_load_use();
        test_mul();
        test_abort(1'b0);
        test_abort(1'b1);
`ifdef FWD_HAZARD_STATS_EN
        test_stats();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
